exc_pc_ctrl: RTL
================

# exc_pc_ctrl

Exception and return sequencer for the multicycle MIPS core. It produces the PC-source select, the EPC value and the handler-vector word that feed the PC-source multiplexer. It detects exceptions, saves the faulting PC, fetches the handler vector byte from memory, and redirects the PC. On `rte` it restores the PC from EPC. It sits beside the main control unit. While `busy` is high, the control unit yields PC and memory-read ownership to this block.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `exc_opcode`  in  1  invalid-opcode exception pulse from control.
- `exc_overflow`  in  1  ALU overflow exception pulse.
- `exc_divzero`  in  1  divide-by-zero exception pulse.
- `rte`  in  1  return-from-exception request pulse.
- `pc`  in  32  current PC value, already incremented by 4.
- `mem_data`  in  32  memory read data; the vector is byte `mem_data[7:0]`.
- `mem_addr`  out  32  byte address of the handler vector.
- `mem_rd`  out  1  memory read strobe.
- `epc`  out  32  saved exception PC.
- `cause`  out  2  last cause: 01 opcode, 10 overflow, 11 divzero; 00 is none.
- `vector_pc`  out  32  zero-extended vector byte; wired to the mux memData input.
- `pc_source`  out  3  PC mux select: 000 ALU result, 010 memData, 100 epc.
- `pc_write`  out  1  PC write enable issued by this block.
- `busy`  out  1  sequence in progress.

## Operation
- States: IDLE, VEC_RD, VEC_WAIT, LOAD, RET.
- IDLE:
  - Outputs: `pc_source`=000, `pc_write`=0, `mem_rd`=0, `busy`=0.
  - Any exception input high: capture `epc` <= `pc` - 32'd4, capture `cause`, latch the vector address, go to VEC_RD.
  - `rte` high with no exception: go to RET.
- Exception priority when several are high in the same cycle: opcode > overflow > divzero.
- Vector byte addresses:
  - opcode: 32'd253
  - overflow: 32'd254
  - divzero: 32'd255
- VEC_RD: `mem_addr`=vector, `mem_rd`=1, `busy`=1; go to VEC_WAIT.
- VEC_WAIT: `mem_addr` held, `mem_rd`=0, `busy`=1. At the end of the cycle, `vector_pc` <= {24'b0, `mem_data[7:0]`}. Go to LOAD.
- LOAD: `pc_source`=010, `pc_write`=1, `busy`=1; go to IDLE.
- RET: `pc_source`=100, `pc_write`=1, `busy`=1; go to IDLE. `epc` and `cause` are unchanged.
- Exception or `rte` inputs arriving while not in IDLE are ignored; they are not queued.
- An exception and `rte` in the same IDLE cycle: the exception wins and `rte` is dropped.
- `epc` and `cause` hold their values until the next accepted exception.
- `pc` - 4 wraps modulo 2^32; `pc`=0 gives `epc`=32'hFFFF_FFFC.
- `mem_addr` holds its last vector value outside VEC_RD and VEC_WAIT.

## Timing
- Exception sampled at edge E:
  - VEC_RD during cycle E+1.
  - Memory data sampled at the end of VEC_WAIT (E+2).
  - LOAD during E+3, so the PC is written at edge E+4.
  - Exception-to-PC-write latency: 4 edges. `busy` is high for cycles E+1 through E+3.
- `rte` sampled at edge R: RET during R+1, PC written at edge R+2.
- Memory contract: read data is valid one cycle after the cycle in which `mem_rd` is high.
- Reset asserted (`reset`=0) at any time, including mid-sequence:
  - State returns to IDLE immediately.
  - `epc`, `vector_pc` and `mem_addr` go to 0; `cause` goes to 00.
  - `pc_source` goes to 000; `pc_write`, `mem_rd` and `busy` go to 0.
  - Any in-flight sequence is aborted; no PC write occurs.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.

## Configuration
- `EXC_DIVZERO_EN` defined: `exc_divzero` is a live exception source with cause 11 and vector 255.
- `EXC_DIVZERO_EN` undefined:
  - `exc_divzero` is ignored.
  - Cause 11 is never produced.
  - A divzero pulse in IDLE leaves all state and outputs unchanged.

## Test plan
- Reset, then `exc_overflow`=1 with `pc`=32'h0000_0104 and mem byte 0x40 → `epc`=32'h0000_0100, `cause`=10, `mem_addr`=254; `pc_write`=1 with `pc_source`=010 and `vector_pc`=32'h40 exactly 3 cycles after the sample edge.
- `exc_opcode` and `exc_divzero` in the same cycle, `pc`=32'h20 → `cause`=01, `mem_addr`=253, `epc`=32'h1C.
- After an exception, `rte` pulse in IDLE → one cycle with `pc_source`=100 and `pc_write`=1; `epc` unchanged.
- `exc_overflow` pulsed again during VEC_WAIT → ignored; `epc` and `cause` retain the first capture; a single LOAD cycle occurs.
- `reset`=0 during VEC_WAIT → next cycle all outputs are at reset values; `pc_write` never asserts.
- Build without `EXC_DIVZERO_EN`, `exc_divzero`=1 → `busy` stays 0 and `cause` stays 00. Build with it → `mem_addr`=255 and `cause`=11.

Source files
------------

// File: rtl/exc_pc_ctrl.sv
// Exception/return sequencer: saves EPC, fetches the handler vector byte and redirects the PC.
// Optional build macro EXC_DIVZERO_EN makes exc_divzero a live exception source.
module exc_pc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic        rte,
  input  logic [31:0] pc,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [31:0] vector_pc,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        busy
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned VEC_W   = 8;

  localparam logic [2:0] SRC_ALU = 3'b000;
  localparam logic [2:0] SRC_MEM = 3'b010;
  localparam logic [2:0] SRC_EPC = 3'b100;

  localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
  localparam logic [1:0] CAUSE_DIVZERO  = 2'b11;

  localparam logic [XLEN-1:0] VEC_OPCODE   = XLEN'(253);
  localparam logic [XLEN-1:0] VEC_OVERFLOW = XLEN'(254);
  localparam logic [XLEN-1:0] VEC_DIVZERO  = XLEN'(255);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEC_RD,
    S_VEC_WAIT,
    S_LOAD,
    S_RET
  } state_t;

  state_t          state;
  logic            divzero_live;
  logic            exc_any;
  logic [1:0]      exc_cause;
  logic [XLEN-1:0] exc_vec;

`ifdef EXC_DIVZERO_EN
  assign divzero_live = exc_divzero;
  logic [XLEN-VEC_W-1:0] unused_mem_hi;
  assign unused_mem_hi = mem_data[XLEN-1:VEC_W];
`else
  assign divzero_live = 1'b0;
  logic [XLEN-VEC_W:0] unused_mem_hi;
  assign unused_mem_hi = {exc_divzero, mem_data[XLEN-1:VEC_W]};
`endif

  // Priority encode the exception sources: opcode > overflow > divzero.
  always_comb begin
    exc_any   = exc_opcode | exc_overflow | divzero_live;
    exc_cause = CAUSE_DIVZERO;
    exc_vec   = VEC_DIVZERO;
    if (exc_opcode) begin
      exc_cause = CAUSE_OPCODE;
      exc_vec   = VEC_OPCODE;
    end else if (exc_overflow) begin
      exc_cause = CAUSE_OVERFLOW;
      exc_vec   = VEC_OVERFLOW;
    end
  end

  // Outputs are registered with the state so each reflects the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      epc       <= '0;
      cause     <= '0;
      mem_addr  <= '0;
      vector_pc <= '0;
      mem_rd    <= 1'b0;
      pc_source <= SRC_ALU;
      pc_write  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      pc_source <= SRC_ALU;
      pc_write  <= 1'b0;
      busy      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (exc_any) begin
            state    <= S_VEC_RD;
            epc      <= pc - XLEN'(4);
            cause    <= exc_cause;
            mem_addr <= exc_vec;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
          end else if (rte) begin
            state     <= S_RET;
            pc_source <= SRC_EPC;
            pc_write  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_VEC_RD: begin
          state <= S_VEC_WAIT;
          busy  <= 1'b1;
        end
        S_VEC_WAIT: begin
          state     <= S_LOAD;
          vector_pc <= {(XLEN-VEC_W)'(0), mem_data[VEC_W-1:0]};
          pc_source <= SRC_MEM;
          pc_write  <= 1'b1;
          busy      <= 1'b1;
        end
        S_LOAD:  state <= S_IDLE;
        S_RET:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
